// File: rtl/csr_exec_unit_if.sv
// Decode-side request, CSR file read/write ports and register-file writeback
// for the Zicsr sequencer. The slave modport is the sequencer's view.
interface csr_exec_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_val;
    logic [4:0]  req_rd_idx;
    logic [11:0] req_csr;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        retire_inst;
    logic        illegal_inst;

    modport slave (
        input  req_valid, req_funct3, req_rs1_idx, req_rs1_val, req_rd_idx, req_csr,
        input  csr_rdata,
        output req_ready, csr_addr, csr_write, csr_waddr, csr_wdata,
        output rd_we, rd_addr, rd_data, retire_inst, illegal_inst
    );

    modport master (
        output req_valid, req_funct3, req_rs1_idx, req_rs1_val, req_rd_idx, req_csr,
        output csr_rdata,
        input  req_ready, csr_addr, csr_write, csr_waddr, csr_wdata,
        input  rd_we, rd_addr, rd_data, retire_inst, illegal_inst
    );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr sequencer: latch request, read CSR (READ), then drive CSR write,
// rd writeback and retire/illegal pulse for one cycle (WRITE).
module csr_exec_unit (
    input  logic              clk,
    input  logic              rst,
    csr_exec_unit_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [4:0]  rs1_idx_q;
    logic [31:0] rs1_val_q;
    logic [4:0]  rd_idx_q;
    logic [11:0] csr_q;
    logic [31:0] old_val;

    logic        is_rw, is_rs, bad_funct, will_write, read_only, legal;
    logic [31:0] src, new_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            rs1_idx_q <= '0;
            rs1_val_q <= '0;
            rd_idx_q  <= '0;
            csr_q     <= '0;
            old_val   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid) begin
                funct3_q  <= bus.req_funct3;
                rs1_idx_q <= bus.req_rs1_idx;
                rs1_val_q <= bus.req_rs1_val;
                rd_idx_q  <= bus.req_rd_idx;
                csr_q     <= bus.req_csr;
            end
            if (state_q == READ) begin
                old_val <= bus.csr_rdata;
            end
        end
    end

    // Decode works on latched fields; funct3[1:0]==0 covers both 000 and 100.
    always_comb begin
        bad_funct  = (funct3_q[1:0] == 2'b00);
        is_rw      = (funct3_q[1:0] == 2'b01);
        is_rs      = (funct3_q[1:0] == 2'b10);
        src        = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;
        will_write = is_rw || (rs1_idx_q != 5'd0);
        read_only  = (csr_q[11:10] == 2'b11);
        legal      = !bad_funct && !(read_only && will_write);
        if (is_rw) begin
            new_val = src;
        end else if (is_rs) begin
            new_val = old_val | src;
        end else begin
            new_val = old_val & ~src;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready    = (state_q == IDLE) && !rst;
        bus.csr_addr     = csr_q;
        bus.csr_waddr    = csr_q;
        bus.csr_write    = 1'b0;
        bus.csr_wdata    = '0;
        bus.rd_we        = 1'b0;
        bus.rd_addr      = '0;
        bus.rd_data      = '0;
        bus.retire_inst  = 1'b0;
        bus.illegal_inst = 1'b0;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Gating with rst keeps an aborted WRITE from reaching the CSR file on the reset edge.
        if (state_q == WRITE && !rst) begin
            bus.csr_write    = legal && will_write;
            bus.csr_wdata    = new_val;
            bus.rd_we        = legal && (rd_idx_q != 5'd0);
            bus.rd_addr      = rd_idx_q;
            bus.rd_data      = old_val;
            bus.retire_inst  = legal;
            bus.illegal_inst = !legal;
        end
    end
endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit with a small behavioural CSR file.
module tb_csr_exec_unit;
    logic clk;
    logic rst;
    csr_exec_unit_if bus ();

    csr_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        rdwe;
        logic [4:0]  rda;
        logic [31:0] rdd;
        logic        ret;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] cyc = '0;
    logic [31:0] fmem[4];
    logic [31:0] rmem[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned slot(input logic [11:0] a);
        case (a)
            12'h340: return 0;
            12'h300: return 1;
            12'h305: return 2;
            default: return 3;
        endcase
    endfunction

    // Behavioural CSR file: counters at 0xC00/0xC02, constant ID at other 0xC/0xF addresses.
    always @(posedge clk) cyc <= cyc + 32'd1;

    always_comb begin
        if (bus.csr_addr[11:10] == 2'b11)
            bus.csr_rdata = (bus.csr_addr == 12'hC00 || bus.csr_addr == 12'hC02) ? cyc : 32'h0000_0489;
        else
            bus.csr_rdata = fmem[slot(bus.csr_addr)];
    end

    always @(posedge clk) begin
        if (bus.csr_write && bus.csr_waddr[11:10] != 2'b11)
            fmem[slot(bus.csr_waddr)] <= (slot(bus.csr_waddr) == 1) ? (bus.csr_wdata & 32'h888) : bus.csr_wdata;
    end

    task automatic predict(input logic [2:0] f3, input logic [4:0] idx, input logic [31:0] val,
                           input logic [4:0] rd, input logic [11:0] csr, input bit track, output exp_t e);
        logic [31:0] old, src, nv;
        bit rw, bad, will, ill;
        if (csr[11:10] == 2'b11)
            old = (csr == 12'hC00 || csr == 12'hC02) ? cyc + 32'd1 : 32'h0000_0489;
        else
            old = rmem[slot(csr)];
        src  = f3[2] ? {27'b0, idx} : val;
        rw   = (f3[1:0] == 2'b01);
        bad  = (f3[1:0] == 2'b00);
        will = rw || (idx != 5'd0);
        ill  = bad || (csr[11:10] == 2'b11 && will);
        if (rw)                 nv = src;
        else if (f3[1:0] == 2) nv = old | src;
        else                    nv = old & ~src;
        e.wr    = !ill && will;
        e.waddr = csr;
        e.wdata = nv;
        e.rdwe  = !ill && (rd != 5'd0);
        e.rda   = rd;
        e.rdd   = old;
        e.ret   = !ill;
        e.ill   = ill;
        if (track && e.wr)
            rmem[slot(csr)] = (slot(csr) == 1) ? (nv & 32'h888) : nv;
    endtask

    // Called at a negedge; returns at the negedge of the READ cycle.
    task automatic issue(input logic [2:0] f3, input logic [4:0] idx, input logic [31:0] val,
                         input logic [4:0] rd, input logic [11:0] csr, input bit track,
                         output logic [31:0] acc_cyc);
        exp_t e;
        int unsigned w = 0;
        acc_cyc = '0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        predict(f3, idx, val, rd, csr, track, e);
        if (track) sb.push_back(e);
        bus.req_valid   = 1'b1;
        bus.req_funct3  = f3;
        bus.req_rs1_idx = idx;
        bus.req_rs1_val = val;
        bus.req_rd_idx  = rd;
        bus.req_csr     = csr;
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.csr_write || bus.rd_we || bus.retire_inst || bus.illegal_inst) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("csr_write", {31'b0, bus.csr_write}, {31'b0, e.wr});
                check("rd_we", {31'b0, bus.rd_we}, {31'b0, e.rdwe});
                check("retire_inst", {31'b0, bus.retire_inst}, {31'b0, e.ret});
                check("illegal_inst", {31'b0, bus.illegal_inst}, {31'b0, e.ill});
                if (e.wr) begin
                    check("csr_wdata", bus.csr_wdata, e.wdata);
                    check("csr_waddr", {20'b0, bus.csr_waddr}, {20'b0, e.waddr});
                end
                if (e.rdwe) begin
                    check("rd_addr", {27'b0, bus.rd_addr}, {27'b0, e.rda});
                    check("rd_data", bus.rd_data, e.rdd);
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, {bus.csr_write, bus.rd_we, bus.retire_inst, bus.illegal_inst,
                               bus.rd_addr, bus.csr_addr, 11'b0}, '0);
        check({tag, "_data"}, bus.rd_data | bus.csr_wdata | {20'b0, bus.csr_waddr}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a1, a2, dummy;
        fmem[0] = 32'h1234_5678; fmem[1] = '0; fmem[2] = '0; fmem[3] = '0;
        rmem[0] = 32'h1234_5678; rmem[1] = '0; rmem[2] = '0; rmem[3] = '0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_rs1_idx = '0;
        bus.req_rs1_val = '0; bus.req_rd_idx = '0; bus.req_csr = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("ready_in_reset", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

        issue(3'b001, 5'd1, 32'hDEAD_BEEF, 5'd5, 12'h340, 1'b1, dummy);
        issue(3'b010, 5'd0, 32'h0,         5'd6, 12'h340, 1'b1, dummy);
        issue(3'b010, 5'd2, 32'h0000_FFFF, 5'd1, 12'h300, 1'b1, dummy);
        issue(3'b011, 5'd3, 32'h0000_0008, 5'd1, 12'h300, 1'b1, dummy);
        issue(3'b110, 5'd0, 32'h0,         5'd7, 12'hC00, 1'b1, dummy);
        issue(3'b001, 5'd4, 32'h5555_5555, 5'd2, 12'hC02, 1'b1, dummy);
        issue(3'b111, 5'd3, 32'h0,         5'd2, 12'hF11, 1'b1, dummy);
        issue(3'b100, 5'd1, 32'h0,         5'd2, 12'h340, 1'b1, dummy);
        issue(3'b000, 5'd0, 32'h0,         5'd2, 12'h340, 1'b1, dummy);
        issue(3'b001, 5'd9, 32'h0000_0100, 5'd0, 12'h305, 1'b1, dummy);
        issue(3'b101, 5'd19, 32'hFFFF_FFFF, 5'd3, 12'h340, 1'b1, dummy);
        issue(3'b110, 5'd12, 32'h0,        5'd4, 12'h340, 1'b1, dummy);
        issue(3'b111, 5'd3, 32'h0,         5'd4, 12'h340, 1'b1, dummy);
        issue(3'b010, 5'd0, 32'h0,         5'd5, 12'hF11, 1'b1, dummy);

        // Abort in READ
        issue(3'b001, 5'd1, 32'h0BAD_0BAD, 5'd5, 12'h340, 1'b0, dummy);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_read");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst_read", {31'b0, bus.req_ready}, 32'd1);

        // Abort in WRITE
        issue(3'b001, 5'd1, 32'h0BAD_0BAD, 5'd5, 12'h340, 1'b0, dummy);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_write_nowrite", {31'b0, bus.csr_write | bus.retire_inst}, 32'd0);
        @(negedge clk);
        check_quiet("rst_write");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst_write", {31'b0, bus.req_ready}, 32'd1);
        check("mscratch_kept", fmem[0], rmem[0]);

        issue(3'b010, 5'd0, 32'h0, 5'd6, 12'h340, 1'b1, dummy);
        issue(3'b001, 5'd1, 32'h0000_0001, 5'd8, 12'h341, 1'b1, a0);
        issue(3'b001, 5'd1, 32'h0000_0002, 5'd8, 12'h341, 1'b1, a1);
        issue(3'b001, 5'd1, 32'h0000_0003, 5'd8, 12'h341, 1'b1, a2);
        check("issue_gap_1", a1 - a0, 32'd3);
        check("issue_gap_2", a2 - a1, 32'd3);

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        check("mstatus_file", fmem[1], 32'h0000_0880);
        check("mtvec_file", fmem[2], 32'h0000_0100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Sequencer for the six Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms). Takes an accepted CSR instruction from decode and performs a read phase on the CSR file's combinational read port. It then performs a write phase that drives the CSR file's write port and the integer register-file writeback port. It also raises the per-instruction retire pulse that feeds the CSR file's instret counter. It sits directly upstream of the CSR file and downstream of decode.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  decode presents a CSR instruction
- req_ready  out  1  unit can accept; high only in IDLE and rst low
- req_funct3  in  3  instruction funct3
- req_rs1_idx  in  5  rs1 field; also the zero-extended uimm for immediate forms
- req_rs1_val  in  32  rs1 register value
- req_rd_idx  in  5  destination register
- req_csr  in  12  CSR address field
- csr_addr  out  12  to CSR file read address
- csr_rdata  in  32  from CSR file, combinational on csr_addr
- csr_write  out  1  CSR file write strobe
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  32  CSR file write data
- rd_we  out  1  register-file write enable
- rd_addr  out  5  register-file write index
- rd_data  out  32  register-file write data (old CSR value)
- retire_inst  out  1  one-cycle pulse per completed legal instruction
- illegal_inst  out  1  one-cycle pulse per rejected instruction

## Operation
- FSM states: IDLE, READ, WRITE.
  - IDLE → READ on req_valid & req_ready. All req_* fields are latched on that edge.
  - READ → WRITE unconditionally. csr_rdata is latched into old_val at the end of READ.
  - WRITE → IDLE unconditionally.
- funct3 decode: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI. 000 and 100 are illegal.
- Operand: src = req_rs1_val for funct3[2]=0. src = {27'b0, req_rs1_idx} for funct3[2]=1.
- New value:
  - RW/RWI: new = src
  - RS/RSI: new = old_val | src
  - RC/RCI: new = old_val & ~src
- Write suppression:
  - RS/RC/RSI/RCI with req_rs1_idx==0 do not write; only the read occurs.
  - RW/RWI always write.
- Read-only rule: a CSR with req_csr[11:10]==2'b11 (covers 0xC00–0xC82, 0xF11–0xF14) is illegal only if a write would occur. A pure read of it is legal.
- rd_we = legal & (req_rd_idx != 0). rd_data = old_val (the pre-write value).
- Illegal instruction:
  - No csr_write, no rd_we, no retire_inst.
  - illegal_inst=1 in WRITE.
  - FSM still walks READ→WRITE→IDLE.
- csr_addr and csr_waddr are both driven from the latched req_csr in every state.

## Timing
- Reset (rst high at an edge): state=IDLE; latched fields and old_val cleared to 0. Outputs are 0: csr_addr, csr_write, csr_waddr, csr_wdata, rd_we, rd_addr, rd_data, retire_inst, illegal_inst.
- req_ready is 0 while rst is high, and 1 from the first cycle after rst deasserts.
- Cycle timeline, with cycle 0 = the accept edge:
  - Cycle 1 (READ): csr_addr valid; csr_rdata sampled at the end of cycle 1.
  - Cycle 2 (WRITE):
    - csr_write, csr_wdata, rd_we, rd_addr, rd_data, retire_inst / illegal_inst are valid for exactly this one cycle.
    - The CSR file captures the write at the end of cycle 2.
  - Cycle 3: IDLE, req_ready=1.
  - Minimum issue interval is 3 cycles.
- All WRITE-phase outputs are registered-decoded from state. They are 0 in IDLE and READ.
- Counter reads return the counter value present during the READ cycle.
- Back-to-back dependency: a write in cycle 2 is visible to the next instruction's READ (cycle 4 at the earliest).
- Reset mid-operation: rst in READ or WRITE aborts. No csr_write and no retire occur on that edge or after; the latched instruction is discarded.
- req_valid with req_ready=0 is ignored; decode holds the request.

## Test plan
- CSRRW x5, mscratch(0x340), rs1=0xDEADBEEF, old=0x12345678: cycle 2 has csr_write=1, csr_wdata=0xDEADBEEF, rd_we=1, rd_addr=5, rd_data=0x12345678, retire_inst=1. A readback by CSRRS x6,0x340,x0 returns 0xDEADBEEF with csr_write=0.
- CSRRS mstatus, rs1_val=0x0000FFFF, old=0: csr_wdata=0x0000FFFF. The file masks this to 0x00000888. A subsequent CSRRC with rs1_val=0x8 gives csr_wdata=0x880.
- CSRRSI rd=x7, uimm=0, csr=0xC00 (cycle): legal; csr_write=0; rd_data equals the cycle counter low word during READ; retire_inst=1.
- CSRRW 0xC02 and CSRRCI 0xF11 with uimm=3: illegal_inst=1, csr_write=0, rd_we=0, retire_inst=0. funct3=100 gives the same result.
- rd=x0 CSRRW to mtvec(0x305), data 0x100: csr_write=1, rd_we=0.
- Assert rst during READ, and separately during WRITE: no csr_write or retire_inst pulse, all outputs 0 next cycle, req_ready=1 the cycle after rst drops. Three back-to-back requests accept on cycles 0, 3 and 6.
